// File: rtl/decode_ctrl_stage_if.sv
// decode_ctrl_stage_if: bundles the fetch-side handshake, hazard/flush inputs
// and the registered decode outputs of decode_ctrl_stage.
//   master : upstream/EX side (drives instr, pc_in, in_valid, flush, hazard
//            info and out_ready; observes in_ready and the decoded fields)
//   slave  : the decode stage itself
interface decode_ctrl_stage_if #(
    parameter int unsigned XLEN = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       instr;
    logic [XLEN-1:0]   pc_in;
    logic              flush;
    logic              ex_memread;
    logic [4:0]        ex_rd;
    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   pc_out;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [4:0]        rd;
    logic [1:0]        alu_src;
    logic [1:0]        reg_in_sel;
    logic [1:0]        branch;
    logic [4:0]        alu_op;
    logic [XLEN-1:0]   imm;
    logic [XLEN/8-1:0] dwe;
    logic              mem_reg;
    logic              reg_wr;
    logic              illegal;

    modport master (
        output in_valid, instr, pc_in, flush, ex_memread, ex_rd, out_ready,
        input  in_ready, out_valid, pc_out, rs1, rs2, rd, alu_src, reg_in_sel,
               branch, alu_op, imm, dwe, mem_reg, reg_wr, illegal
    );

    modport slave (
        input  in_valid, instr, pc_in, flush, ex_memread, ex_rd, out_ready,
        output in_ready, out_valid, pc_out, rs1, rs2, rd, alu_src, reg_in_sel,
               branch, alu_op, imm, dwe, mem_reg, reg_wr, illegal
    );
endinterface

// File: rtl/decode_ctrl_stage.sv
// decode_ctrl_stage: registered RV32/RV64 decode/control stage.
// Decodes one instruction per cycle into ALU, branch, memory and writeback
// controls plus a sign-extended immediate, held in an output register behind
// a valid/ready handshake. Inserts load-use bubbles, honours flush, and holds
// issue for DIV_CYCLES cycles after a divide/remainder.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - decode_ctrl_stage_if.slave (input handshake, flush, EX hazard info,
//          output handshake and registered decode fields)
module decode_ctrl_stage #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned EN_MULDIV  = 1,
    parameter int unsigned DIV_CYCLES = 32
) (
    input logic                 clk,
    input logic                 rst,
    decode_ctrl_stage_if.slave  bus
);

    localparam int unsigned NB = XLEN / 8;
    localparam int unsigned CW = $clog2(DIV_CYCLES + 1);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;

    typedef enum logic [0:0] {StRun, StDivWait} state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [1:0]      alu_src;
        logic [1:0]      reg_in_sel;
        logic [1:0]      branch;
        logic [4:0]      alu_op;
        logic [XLEN-1:0] imm;
        logic [NB-1:0]   dwe;
        logic            mem_reg;
        logic            reg_wr;
        logic            illegal;
    } dec_t;

    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        is_m;
    logic        is_div;
    logic        store_bad;
    logic        rs1_used;
    logic        rs2_used;
    logic        hazard;
    logic        in_ready;
    logic        accept;

    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    dec_t   dec;
    dec_t   out_d, out_q;
    logic   out_valid_d, out_valid_q;
    state_e state_d, state_q;
    logic [CW-1:0] cnt_d, cnt_q;

    assign instr  = bus.instr;
    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign is_m   = (opcode == OP_RTYPE) && (instr[31:25] == 7'b0000001);
    assign is_div = is_m && funct3[2] && (EN_MULDIV != 0);

    // Funct3 values beyond the widest supported store (SW on RV32, SD on RV64).
    assign store_bad = funct3[2] || ((XLEN != 64) && (funct3 == 3'b011));

    assign imm_i = {{(XLEN-11){instr[31]}}, instr[30:20]};
    assign imm_s = {{(XLEN-11){instr[31]}}, instr[30:25], instr[11:7]};
    assign imm_b = {{(XLEN-12){instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {{(XLEN-31){instr[31]}}, instr[30:12], 12'b0};
    assign imm_j = {{(XLEN-20){instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};

    // Load-use hazard against the instruction presented this cycle.
    assign rs1_used = !((opcode == OP_LUI) || (opcode == OP_AUIPC) || (opcode == OP_JAL));
    assign rs2_used = (opcode == OP_RTYPE) || (opcode == OP_STORE) || (opcode == OP_BRANCH);
    assign hazard   = bus.ex_memread && (bus.ex_rd != 5'd0) &&
                      (((bus.ex_rd == instr[19:15]) && rs1_used) ||
                       ((bus.ex_rd == instr[24:20]) && rs2_used));

    assign in_ready = !bus.flush && !hazard && (state_q == StRun) &&
                      (!out_valid_q || bus.out_ready);
    assign accept   = bus.in_valid && in_ready;

    // Combinational decode of the presented instruction.
    always_comb begin
        dec         = '0;
        dec.pc      = bus.pc_in;
        dec.rs1     = instr[19:15];
        dec.rs2     = instr[24:20];
        dec.rd      = instr[11:7];
        dec.illegal = 1'b0;
        case (opcode)
            OP_LUI: begin
                dec.reg_in_sel = 2'b10;
                dec.imm        = imm_u;
            end
            OP_AUIPC: begin
                dec.alu_src = 2'b11;
                dec.imm     = imm_u;
            end
            OP_JAL: begin
                dec.branch     = 2'b11;
                dec.reg_in_sel = 2'b11;
                dec.imm        = imm_j;
            end
            OP_JALR: begin
                dec.branch     = 2'b10;
                dec.reg_in_sel = 2'b11;
                dec.alu_src    = 2'b10;
                dec.imm        = imm_i;
            end
            OP_BRANCH: begin
                dec.branch = 2'b01;
                dec.imm    = imm_b;
                // Compare ops: BEQ/BNE subtract, BLT/BGE slt, BLTU/BGEU sltu.
                case (funct3[2:1])
                    2'b00:   dec.alu_op = 5'b01000;
                    2'b10:   dec.alu_op = 5'b00010;
                    2'b11:   dec.alu_op = 5'b00011;
                    default: dec.alu_op = 5'b00000;
                endcase
            end
            OP_LOAD: begin
                dec.mem_reg = 1'b1;
                dec.alu_src = 2'b10;
                dec.imm     = imm_i;
            end
            OP_STORE: begin
                dec.alu_src = 2'b10;
                dec.imm     = imm_s;
                if (store_bad) begin
                    dec.illegal = 1'b1;
                end else begin
                    case (funct3[1:0])
                        2'b00:   dec.dwe = NB'(8'h01);
                        2'b01:   dec.dwe = NB'(8'h03);
                        2'b10:   dec.dwe = NB'(8'h0F);
                        default: dec.dwe = NB'(8'hFF);
                    endcase
                end
            end
            OP_ITYPE: begin
                dec.alu_src = 2'b10;
                dec.imm     = imm_i;
                dec.alu_op  = {2'b00, funct3};
            end
            OP_RTYPE: begin
                dec.alu_op = {is_m, instr[30], funct3};
                if (is_m && (EN_MULDIV == 0)) begin
                    dec.illegal = 1'b1;
                end
            end
            default: dec.illegal = 1'b1;
        endcase

        dec.reg_wr = !((opcode == OP_STORE) || (opcode == OP_BRANCH) || (dec.rd == 5'd0));

        // Illegal instructions carry only their PC and the illegal flag.
        if (dec.illegal) begin
            dec         = '0;
            dec.pc      = bus.pc_in;
            dec.illegal = 1'b1;
        end
    end

    // Issue-hold FSM for multi-cycle divides.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (bus.flush) begin
            state_d = StRun;
            cnt_d   = '0;
        end else begin
            case (state_q)
                StRun: begin
                    if (accept && is_div) begin
                        state_d = StDivWait;
                        cnt_d   = CW'(DIV_CYCLES - 1);
                    end
                end
                StDivWait: begin
                    if (cnt_q == '0) begin
                        state_d = StRun;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                default: begin
                    state_d = StRun;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Output register: flush > accept > consume > hold.
    always_comb begin
        out_d       = out_q;
        out_valid_d = out_valid_q;
        if (bus.flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_d       = dec;
            out_valid_d = 1'b1;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StRun;
            cnt_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = out_valid_q;
    assign bus.pc_out     = out_q.pc;
    assign bus.rs1        = out_q.rs1;
    assign bus.rs2        = out_q.rs2;
    assign bus.rd         = out_q.rd;
    assign bus.alu_src    = out_q.alu_src;
    assign bus.reg_in_sel = out_q.reg_in_sel;
    assign bus.branch     = out_q.branch;
    assign bus.alu_op     = out_q.alu_op;
    assign bus.imm        = out_q.imm;
    assign bus.dwe        = out_q.dwe;
    assign bus.mem_reg    = out_q.mem_reg;
    assign bus.reg_wr     = out_q.reg_wr;
    assign bus.illegal    = out_q.illegal;

endmodule

// File: tb/tb_decode_ctrl_stage.sv
// Directed bench for decode_ctrl_stage: RV32 core instance with DIV_CYCLES=4,
// plus an RV64 instance and an RV32 instance without M support, all driven
// with the same stimulus.
module tb_decode_ctrl_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] instr = 32'd0;
    logic [63:0] pc = 64'd0;
    logic        flush = 1'b0;
    logic        ex_memread = 1'b0;
    logic [4:0]  ex_rd = 5'd0;
    logic        out_ready = 1'b1;

    int ncmp = 0;
    int nfail = 0;

    localparam logic [31:0] I_ADDI = 32'hFFF08293;  // addi x5,x1,-1
    localparam logic [31:0] I_ADD  = 32'h00228333;  // add  x6,x5,x2
    localparam logic [31:0] I_SW   = 32'h0020A423;  // sw   x2,8(x1)
    localparam logic [31:0] I_SD   = 32'h0020B423;  // sd   x2,8(x1)
    localparam logic [31:0] I_JAL  = 32'h008000EF;  // jal  x1,+8
    localparam logic [31:0] I_DIV  = 32'h0220C1B3;  // div  x3,x1,x2
    localparam logic [31:0] I_MUL  = 32'h022081B3;  // mul  x3,x1,x2
    localparam logic [31:0] I_BAD  = 32'h0000007F;  // unknown opcode

    always #5 clk = ~clk;

    decode_ctrl_stage_if #(.XLEN(32)) b32 ();
    decode_ctrl_stage_if #(.XLEN(64)) b64 ();
    decode_ctrl_stage_if #(.XLEN(32)) bnm ();

    assign b32.in_valid = in_valid;   assign b64.in_valid = in_valid;   assign bnm.in_valid = in_valid;
    assign b32.instr = instr;         assign b64.instr = instr;         assign bnm.instr = instr;
    assign b32.pc_in = pc[31:0];      assign b64.pc_in = pc;            assign bnm.pc_in = pc[31:0];
    assign b32.flush = flush;         assign b64.flush = flush;         assign bnm.flush = flush;
    assign b32.ex_memread = ex_memread;
    assign b64.ex_memread = ex_memread;
    assign bnm.ex_memread = ex_memread;
    assign b32.ex_rd = ex_rd;         assign b64.ex_rd = ex_rd;         assign bnm.ex_rd = ex_rd;
    assign b32.out_ready = out_ready; assign b64.out_ready = out_ready; assign bnm.out_ready = out_ready;

    decode_ctrl_stage #(.XLEN(32), .EN_MULDIV(1), .DIV_CYCLES(4)) u_dut (
        .clk (clk), .rst (rst), .bus (b32));
    decode_ctrl_stage #(.XLEN(64), .EN_MULDIV(1), .DIV_CYCLES(4)) u_dut64 (
        .clk (clk), .rst (rst), .bus (b64));
    decode_ctrl_stage #(.XLEN(32), .EN_MULDIV(0), .DIV_CYCLES(4)) u_nomd (
        .clk (clk), .rst (rst), .bus (bnm));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", b32.out_valid, 0);
        chk("rst_pc_out", b32.pc_out, 0);
        chk("rst_imm", b32.imm, 0);
        chk("rst_illegal", b32.illegal, 0);
        chk("rst_reg_wr", b32.reg_wr, 0);
        chk("rst_in_ready", b32.in_ready, 1);

        // addi x5,x1,-1
        step();
        in_valid = 1'b1; instr = I_ADDI; pc = 64'h100;
        @(negedge clk);
        chk("addi_in_ready", b32.in_ready, 1);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("addi_out_valid", b32.out_valid, 1);
        chk("addi_imm", b32.imm, 64'hFFFF_FFFF);
        chk("addi_imm64", b64.imm, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("addi_alu_src", b32.alu_src, 2'b10);
        chk("addi_alu_op", b32.alu_op, 5'b00000);
        chk("addi_reg_wr", b32.reg_wr, 1);
        chk("addi_rd", b32.rd, 5);
        chk("addi_pc_out", b32.pc_out, 64'h100);

        // Load-use: add x6,x5,x2 behind a load to x5
        step();
        in_valid = 1'b1; instr = I_ADD; pc = 64'h104;
        ex_memread = 1'b1; ex_rd = 5'd5;
        @(negedge clk);
        chk("lu_in_ready_stall", b32.in_ready, 0);
        step();
        ex_memread = 1'b0;
        @(negedge clk);
        chk("lu_bubble", b32.out_valid, 0);
        chk("lu_in_ready_free", b32.in_ready, 1);
        step();
        instr = I_SW; pc = 64'h108;
        @(negedge clk);
        chk("add_out_valid", b32.out_valid, 1);
        chk("add_rd", b32.rd, 6);
        chk("add_rs1", b32.rs1, 5);
        chk("add_rs2", b32.rs2, 2);
        chk("add_pc_out", b32.pc_out, 64'h104);

        // Stores
        step();
        instr = I_SD; pc = 64'h10C;
        @(negedge clk);
        chk("sw_dwe", b32.dwe, 4'hF);
        chk("sw_reg_wr", b32.reg_wr, 0);
        chk("sw_imm", b32.imm, 8);
        chk("sw_dwe64", b64.dwe, 8'h0F);
        step();
        instr = I_JAL; pc = 64'h110;
        @(negedge clk);
        chk("sd32_illegal", b32.illegal, 1);
        chk("sd32_dwe", b32.dwe, 0);
        chk("sd32_alu_src", b32.alu_src, 0);
        chk("sd32_pc_out", b32.pc_out, 64'h10C);
        chk("sd64_dwe", b64.dwe, 8'hFF);
        chk("sd64_illegal", b64.illegal, 0);

        // Backpressure with jal x1,+8 held
        step();
        out_ready = 1'b0; instr = I_ADDI; pc = 64'h114;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_out_valid", b32.out_valid, 1);
            chk("bp_branch", b32.branch, 2'b11);
            chk("bp_reg_in_sel", b32.reg_in_sel, 2'b11);
            chk("bp_imm", b32.imm, 8);
            chk("bp_pc_out", b32.pc_out, 64'h110);
            chk("bp_in_ready", b32.in_ready, 0);
            step();
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_in_ready", b32.in_ready, 1);

        // Divide hold: 4 cycles
        step();
        instr = I_DIV; pc = 64'h118;
        @(negedge clk);
        chk("pre_div_pc_out", b32.pc_out, 64'h114);
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("div_wait_in_ready", b32.in_ready, 0);
            if (i == 0) chk("div_alu_op", b32.alu_op, 5'b10100);
            step();
        end
        @(negedge clk);
        chk("div_done_in_ready", b32.in_ready, 1);

        // Divide squashed by flush in its second wait cycle
        in_valid = 1'b1; instr = I_DIV; pc = 64'h11C;
        step();
        in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        chk("divf_w1_in_ready", b32.in_ready, 0);
        chk("divf_w1_out_valid", b32.out_valid, 1);
        step();
        flush = 1'b1; in_valid = 1'b1; instr = I_ADDI; pc = 64'h120;
        @(negedge clk);
        chk("divf_w2_in_ready", b32.in_ready, 0);
        step();
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("flush_out_valid", b32.out_valid, 0);
        chk("flush_in_ready", b32.in_ready, 1);
        chk("flush_pc_out", b32.pc_out, 64'h11C);
        out_ready = 1'b1;

        // mul with and without M support, then an unknown opcode
        in_valid = 1'b1; instr = I_MUL; pc = 64'h124;
        step();
        instr = I_BAD; pc = 64'h128;
        @(negedge clk);
        chk("mul_alu_op", b32.alu_op, 5'b10000);
        chk("mul_illegal", b32.illegal, 0);
        chk("mul_reg_wr", b32.reg_wr, 1);
        chk("mul_in_ready", b32.in_ready, 1);
        chk("nomd_mul_illegal", bnm.illegal, 1);
        chk("nomd_mul_reg_wr", bnm.reg_wr, 0);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("bad_illegal", b32.illegal, 1);
        chk("bad_reg_wr", b32.reg_wr, 0);
        chk("bad_pc_out", b32.pc_out, 64'h128);

        // Asynchronous reset during a divide wait
        in_valid = 1'b1; instr = I_DIV; pc = 64'h12C;
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("rstdiv_in_ready_wait", b32.in_ready, 0);
        #2 rst = 1'b1;
        #1;
        chk("rstdiv_in_ready", b32.in_ready, 1);
        chk("rstdiv_out_valid", b32.out_valid, 0);
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule

// File: doc/decode_ctrl_stage.md
# decode_ctrl_stage

Registered instruction-decode/control stage for the pipelined RV32/RV64 core. It sits between the IF/ID and ID/EX boundaries and decodes one instruction per cycle into ALU, branch, memory and writeback controls plus a sign-extended immediate. Unlike the plain combinational decoder, it holds results in an output register with a valid/ready handshake, inserts load-use bubbles, and honours a pipeline flush. When M-extension support is enabled, it also holds issue for a fixed number of cycles after a divide or remainder instruction.

## Interface
- `XLEN`, default 32: datapath width (32 or 64); sets `imm` and `pc` widths.
- `EN_MULDIV`, default 1: 1 decodes M-extension ops; 0 flags them illegal.
- `DIV_CYCLES`, default 32: issue-hold cycles after DIV/DIVU/REM/REMU (≥1).
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  instruction present on `instr`/`pc_in`.
- `in_ready`  out  1  stage accepts the instruction this cycle.
- `instr`  in  32  instruction word; opcodes per `parameters.vh`.
- `pc_in`  in  XLEN  PC of `instr`.
- `flush`  in  1  synchronous squash, highest priority.
- `ex_memread`  in  1  instruction currently in EX is a LOAD.
- `ex_rd`  in  5  destination register of the EX instruction.
- `out_valid`  out  1  output register holds a decoded instruction.
- `out_ready`  in  1  EX consumes the output this cycle.
- `pc_out`  out  XLEN  registered PC.
- `rs1`, `rs2`, `rd`  out  5 each  registered register indices.
- `alu_src`  out  2  bit0 = PC operand (AUIPC); bit1 = immediate operand (ITYPE/LOAD/STORE/JALR/AUIPC).
- `reg_in_sel`  out  2  writeback source: 00 = ALU, 11 = PC+4 (JAL/JALR), 10 = immediate (LUI).
- `branch`  out  2  01 = conditional, 11 = JAL, 10 = JALR, 00 = none.
- `alu_op`  out  5  {muldiv, instr[30] for RTYPE else 0, funct3}. SBTYPE maps funct3[2:1] 00→01000, 10→00010, 11→00011.
- `imm`  out  XLEN  sign-extended I/S/B/U/J immediate; 0 for RTYPE.
- `dwe`  out  XLEN/8  store byte enables: SB 0x01, SH 0x03, SW 0x0F, SD 0xFF (XLEN=64 only).
- `mem_reg`  out  1  LOAD.
- `reg_wr`  out  1  writeback enable.
- `illegal`  out  1  undecodable instruction.

## Operation
- Accept happens when `in_valid & in_ready`.
- `in_ready` = `~flush & ~hazard & (state==RUN) & (~out_valid | out_ready)`.
- Hazard condition: `ex_memread & ex_rd!=0`, and one of:
  - `ex_rd==rs1` and rs1 is used (every opcode except LUI, AUIPC, JAL);
  - `ex_rd==rs2` and rs2 is used (RTYPE, STORE, SBTYPE).
- Output register update, in priority order:
  - flush: `out_valid`←0.
  - accept: all fields load, `out_valid`←1.
  - `out_ready`: `out_valid`←0 (this is the bubble on a hazard).
  - otherwise: hold all fields.
- `reg_wr` = 0 for STORE, SBTYPE, illegal, or `rd==0`; otherwise 1.
- `dwe` = 0 for anything other than a legal store.
- Illegal conditions:
  - unknown opcode;
  - store funct3 > 2 when XLEN=32, or > 3 when XLEN=64;
  - M op (RTYPE, funct7 = 0000001) with `EN_MULDIV`=0.
- On illegal, every control output is 0 except `illegal`=1, `out_valid`=1, and `pc_out`.
- FSM states:
  - RUN: accepting a DIV/DIVU/REM/REMU (funct3[2]=1) moves to DIV_WAIT and sets `cnt`←DIV_CYCLES−1.
  - DIV_WAIT: `in_ready`=0; `cnt` decrements each cycle; returns to RUN in the cycle after `cnt`==0.
  - MUL-class ops (funct3[2]=0) do not leave RUN.
- Flush in any state: state←RUN, `cnt`←0, `out_valid`←0.

## Timing
- Latency: an instruction accepted at edge N is visible on the outputs after edge N, for one full cycle minimum.
- Throughput: one instruction per cycle when `out_ready`=1 and no hazard or divide is in progress.
- Reset values: `out_valid`, all control fields, `imm`, `pc_out`, `rs1`/`rs2`/`rd`, `illegal` and `cnt` are 0; state is RUN.
- After reset, `in_ready`=1 unless a hazard is present.
- Backpressure: with `out_valid=1` and `out_ready=0`, all outputs are held stable and `in_ready`=0.
- Flush and `in_valid` in the same cycle: the instruction is dropped (`in_ready`=0).
- A divide accepted at edge N holds `in_ready` low for exactly DIV_CYCLES cycles after edge N.
- Hazard with `out_ready=1`: exactly one bubble (`out_valid`=0) per stalled cycle; the instruction is accepted on the first hazard-free cycle.
- `rst` asserted mid-divide: returns to RUN immediately (asynchronous).

## Test plan
- Reset, then feed `addi x5,x1,-1` (0xFFF08293) → next cycle `out_valid`=1, `imm`=0xFFFFFFFF, `alu_src`=10, `alu_op`=00000, `reg_wr`=1, `rd`=5.
- Load-use: EX holds a load to x5 (`ex_memread`=1, `ex_rd`=5) and `add x6,x5,x2` is presented → one bubble; drop `ex_memread` → accepted next cycle.
- Store variants: `sw` → `dwe`=0x0F, `reg_wr`=0. With XLEN=64, `sd` → `dwe`=0xFF. With XLEN=32, `sd` → `illegal`=1, `dwe`=0.
- `div x3,x1,x2` with DIV_CYCLES=4 → `in_ready` low for 4 cycles, then high. Assert `flush` during the second wait cycle → `in_ready` high the cycle after the flush, `out_valid`=0.
- Backpressure: `out_ready`=0 for 3 cycles with `jal x1,+8` held in the output → `branch`=11, `reg_in_sel`=11, `imm`=8 remain stable and `in_ready`=0 throughout.
- EN_MULDIV=0 and `mul` → `illegal`=1, `reg_wr`=0. Unknown opcode 0x7F → `illegal`=1.
